// File: rtl/dispatch_router.sv
// In-order dispatch queue with per-class RS credit gating; enqueue->out_valid latency 1 cycle, group-granular in_ready upstream.
// No RS-side backpressure beyond credits. Optional DISPATCH_STATS_EN adds saturating dispatch/credit-stall/queue-full counters.
module dispatch_router #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int QUEUE_DEPTH    = 8,
  parameter int RS_DEPTH       = 16,
  parameter int ROB_WIDTH      = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      stall_dispatch,
  input  logic [DISPATCH_WIDTH-1:0]                 in_valid,
  input  logic [DISPATCH_WIDTH*32-1:0]              in_instr,
  input  logic [DISPATCH_WIDTH*ROB_WIDTH-1:0]       in_rob_id,
  output logic                                      in_ready,
  input  logic [3*$clog2(DISPATCH_WIDTH+1)-1:0]     rs_credit_ret,
  output logic [3*DISPATCH_WIDTH-1:0]               out_valid,
  output logic [3*DISPATCH_WIDTH*32-1:0]            out_instr,
  output logic [3*DISPATCH_WIDTH*ROB_WIDTH-1:0]     out_rob_id
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                               stat_dispatched,
  output logic [3*32-1:0]                           stat_credit_stall,
  output logic [31:0]                               stat_queue_full
`endif
);

  localparam int DW  = DISPATCH_WIDTH;
  localparam int IW  = 32;
  localparam int CRW = $clog2(DW + 1);
  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int OW  = $clog2(QUEUE_DEPTH + 1);
  localparam int CW  = $clog2(RS_DEPTH + 1);
  localparam int SLW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] CLS_ALU = 2'd0;
  localparam logic [1:0] CLS_LSU = 2'd1;
  localparam logic [1:0] CLS_BRU = 2'd2;

  function automatic logic [1:0] classify(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE:             return CLS_LSU;
      OPC_BRANCH, OPC_JAL, OPC_JALR:   return CLS_BRU;
      OPC_IMM, OPC_OP, OPC_LUI,
      OPC_AUIPC, OPC_SYSTEM:           return CLS_ALU;
      default:                         return CLS_ALU;
    endcase
  endfunction

  logic [IW-1:0]        q_instr [QUEUE_DEPTH];
  logic [ROB_WIDTH-1:0] q_rob   [QUEUE_DEPTH];
  logic [1:0]           q_cls   [QUEUE_DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [OW-1:0]        occ;
  logic [CW-1:0]        credit  [3];

  logic                 enq_fire;
  logic [CRW-1:0]       enq_cnt;

  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < DW; i++) enq_cnt = enq_cnt + CRW'(in_valid[i]);
  end

  assign in_ready = (OW'(QUEUE_DEPTH) - occ) >= OW'(DW);
  assign enq_fire = in_ready && (|in_valid) && !flush;

  logic [2:0][DW-1:0]                ov_d;
  logic [2:0][DW-1:0][IW-1:0]        oi_d;
  logic [2:0][DW-1:0][ROB_WIDTH-1:0] or_d;
  logic [CRW-1:0]                    taken [3];
  logic [CRW-1:0]                    deq_cnt;
  logic                              scan_stop;
  logic [PW-1:0]                     idx;
  logic [1:0]                        cls;

  // Oldest-first scan; the first entry whose class is out of credit blocks everything younger.
  always_comb begin
    ov_d      = '0;
    oi_d      = '0;
    or_d      = '0;
    for (int c = 0; c < 3; c++) taken[c] = '0;
    deq_cnt   = '0;
    scan_stop = 1'b0;
    idx       = '0;
    cls       = '0;
    if (!flush && !stall_dispatch) begin
      for (int i = 0; i < DW; i++) begin
        idx = head + PW'(i);
        cls = q_cls[idx];
        if (!scan_stop && (OW'(i) < occ)) begin
          if (credit[cls] > CW'(taken[cls])) begin
            ov_d[cls][SLW'(taken[cls])] = 1'b1;
            oi_d[cls][SLW'(taken[cls])] = q_instr[idx];
            or_d[cls][SLW'(taken[cls])] = q_rob[idx];
            taken[cls] = taken[cls] + CRW'(1);
            deq_cnt    = deq_cnt + CRW'(1);
          end else begin
            scan_stop = 1'b1;
          end
        end
      end
    end
  end

  assign out_valid  = ov_d;
  assign out_instr  = oi_d;
  assign out_rob_id = or_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int c = 0; c < 3; c++) credit[c] <= CW'(RS_DEPTH);
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int c = 0; c < 3; c++) credit[c] <= CW'(RS_DEPTH);
    end else begin
      head <= head + PW'(deq_cnt);
      if (enq_fire) tail <= tail + PW'(enq_cnt);
      occ  <= occ + (enq_fire ? OW'(enq_cnt) : OW'(0)) - OW'(deq_cnt);
      for (int c = 0; c < 3; c++)
        credit[c] <= credit[c] - CW'(taken[c]) + CW'(rs_credit_ret[c*CRW +: CRW]);
    end
  end

  // Payload storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < DW; i++) begin
        if (in_valid[i]) begin
          q_instr[tail + PW'(i)] <= in_instr[i*IW +: IW];
          q_rob[tail + PW'(i)]   <= in_rob_id[i*ROB_WIDTH +: ROB_WIDTH];
          q_cls[tail + PW'(i)]   <= classify(in_instr[i*IW +: 7]);
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [31:0] st_cs [3];
  logic [1:0]  stop_cls;

  // When the scan stops, the blocking entry sits right after the ones that went out.
  assign stop_cls = q_cls[head + PW'(deq_cnt)];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_dispatched <= '0;
      stat_queue_full <= '0;
      for (int c = 0; c < 3; c++) st_cs[c] <= '0;
    end else begin
      stat_dispatched <= sat_add(stat_dispatched, 32'(deq_cnt));
      if (occ == OW'(QUEUE_DEPTH)) stat_queue_full <= sat_add(stat_queue_full, 32'd1);
      for (int c = 0; c < 3; c++)
        if (scan_stop && (stop_cls == 2'(c))) st_cs[c] <= sat_add(st_cs[c], 32'd1);
    end
  end

  assign stat_credit_stall = {st_cs[2], st_cs[1], st_cs[0]};
`endif

  generate
    for (genvar c = 0; c < 3; c++) begin : g_credit_chk
      a_credit_bound: assert property (@(posedge clk) disable iff (!rst) credit[c] <= CW'(RS_DEPTH));
    end
  endgenerate

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: directed vector table, hand-written corner sequences and randomized traffic against a queue model.
module tb_dispatch_router;

  localparam int DW  = 2;
  localparam int QD  = 8;
  localparam int RSD = 16;
  localparam int RW  = 4;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_IMM = 7'b0010011;
  localparam logic [6:0] O_OP = 7'b0110011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_SYS = 7'b1110011, O_UNK = 7'b1111111;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         stall_dispatch;
  logic [1:0]   in_valid;
  logic [63:0]  in_instr;
  logic [7:0]   in_rob_id;
  logic         in_ready;
  logic [5:0]   rs_credit_ret;
  logic [5:0]   out_valid;
  logic [191:0] out_instr;
  logic [23:0]  out_rob_id;
`ifdef DISPATCH_STATS_EN
  logic [31:0]  stat_dispatched;
  logic [95:0]  stat_credit_stall;
  logic [31:0]  stat_queue_full;
`endif

  dispatch_router #(.DISPATCH_WIDTH(DW), .QUEUE_DEPTH(QD), .RS_DEPTH(RSD), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_dispatch(stall_dispatch),
    .in_valid(in_valid), .in_instr(in_instr), .in_rob_id(in_rob_id), .in_ready(in_ready),
    .rs_credit_ret(rs_credit_ret), .out_valid(out_valid), .out_instr(out_instr), .out_rob_id(out_rob_id)
`ifdef DISPATCH_STATS_EN
    , .stat_dispatched(stat_dispatched), .stat_credit_stall(stat_credit_stall), .stat_queue_full(stat_queue_full)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cls;
    logic [31:0] instr;
    logic [3:0]  rob;
  } ent_t;

  typedef struct {
    logic [1:0] v;
    logic [6:0] op0;
    logic [6:0] op1;
    logic       st;
    logic [5:0] ov;
    int         c0;
    int         c1;
    int         c2;
  } vec_t;

  ent_t       mq[$];
  int         mcr[3];
  int         errors = 0;
  int         checks = 0;
  logic [5:0] obs_ov;
  bit         auto_ret = 1'b0;
  logic [3:0] rob_ctr = 4'd0;
  logic [6:0] ops[11];
  vec_t       tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int cls_of(input logic [31:0] ins);
    case (ins[6:0])
      O_LOAD, O_STORE:          return 1;
      O_BRANCH, O_JAL, O_JALR:  return 2;
      default:                  return 0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom();
    return {r[31:7], op};
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < 3; c++) mcr[c] = RSD;
  endtask

  task automatic drive(input logic [1:0] v, input logic [6:0] op0, input logic [6:0] op1,
                       input logic st, input logic fl, input logic [5:0] ret);
    in_valid       = v;
    in_instr       = {mk(op1), mk(op0)};
    in_rob_id      = {rob_ctr + 4'd1, rob_ctr};
    rob_ctr        = rob_ctr + 4'd2;
    stall_dispatch = st;
    flush          = fl;
    rs_credit_ret  = ret;
  endtask

  // Called at posedge+1 with inputs already driven; compares mid-cycle, then advances model and clock.
  task automatic run_cycle();
    int          taken[3];
    int          ndeq;
    bit          exp_rdy;
    logic [5:0]  exp_ov;
    logic [31:0] ei[3][2];
    logic [3:0]  er[3][2];
    ent_t        e;
    for (int c = 0; c < 3; c++) taken[c] = 0;
    ndeq   = 0;
    exp_ov = '0;
    if (!flush && !stall_dispatch) begin
      for (int i = 0; i < DW && i < mq.size(); i++) begin
        int c;
        c = mq[i].cls;
        if (mcr[c] - taken[c] <= 0) break;
        exp_ov[c*DW + taken[c]] = 1'b1;
        ei[c][taken[c]] = mq[i].instr;
        er[c][taken[c]] = mq[i].rob;
        taken[c]++;
        ndeq++;
      end
    end
    exp_rdy = (QD - mq.size()) >= DW;
    if (auto_ret) begin
      for (int c = 0; c < 3; c++) begin
        int room;
        room = RSD - (mcr[c] - taken[c]);
        if (room > DW) room = DW;
        rs_credit_ret[c*2 +: 2] = 2'($urandom_range(room, 0));
      end
    end
    #4;
    obs_ov = out_valid;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < DW; k++)
        if (exp_ov[c*DW + k]) begin
          chk("out_instr", out_instr[(c*DW + k)*32 +: 32], ei[c][k]);
          chk("out_rob_id", out_rob_id[(c*DW + k)*4 +: 4], er[c][k]);
        end
    if (flush) begin
      model_reset();
    end else begin
      for (int n = 0; n < ndeq; n++) void'(mq.pop_front());
      for (int c = 0; c < 3; c++) mcr[c] = mcr[c] - taken[c] + int'(rs_credit_ret[c*2 +: 2]);
      if (exp_rdy && (|in_valid)) begin
        for (int l = 0; l < DW; l++)
          if (in_valid[l]) begin
            e.instr = in_instr[l*32 +: 32];
            e.rob   = in_rob_id[l*4 +: 4];
            e.cls   = cls_of(e.instr);
            mq.push_back(e);
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [1:0] v, input logic [6:0] op0, input logic [6:0] op1,
                     input logic st, input logic fl, input logic [5:0] ret);
    drive(v, op0, op1, st, fl, ret);
    run_cycle();
  endtask

  task automatic chk_credits(input string name, input int a, input int l, input int b);
    chk({name, "_alu"}, 64'(dut.credit[0]), 64'(a));
    chk({name, "_lsu"}, 64'(dut.credit[1]), 64'(l));
    chk({name, "_bru"}, 64'(dut.credit[2]), 64'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int sent;
    int disp;
    logic [1:0] v;
    ops = '{O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_IMM, O_OP, O_LUI, O_AUIPC, O_SYS, O_UNK};

    tbl[0]  = '{2'b11, O_IMM,   O_LOAD,  1'b0, 6'b000000, 16, 16, 16};
    tbl[1]  = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b000101, 16, 16, 16};
    tbl[2]  = '{2'b11, O_BRANCH, O_JAL,  1'b0, 6'b000000, 15, 15, 16};
    tbl[3]  = '{2'b01, O_STORE, O_IMM,   1'b0, 6'b110000, 15, 15, 16};
    tbl[4]  = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b000100, 15, 15, 14};
    tbl[5]  = '{2'b11, O_UNK,   O_AUIPC, 1'b0, 6'b000000, 15, 14, 14};
    tbl[6]  = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b000011, 15, 14, 14};
    tbl[7]  = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b000000, 13, 14, 14};
    tbl[8]  = '{2'b11, O_LOAD,  O_LOAD,  1'b0, 6'b000000, 13, 14, 14};
    tbl[9]  = '{2'b00, O_IMM,   O_IMM,   1'b1, 6'b000000, 13, 14, 14};
    tbl[10] = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b001100, 13, 14, 14};
    tbl[11] = '{2'b00, O_IMM,   O_IMM,   1'b0, 6'b000000, 13, 12, 14};

    rst = 1'b0;
    drive(2'b00, O_IMM, O_IMM, 1'b0, 1'b0, 6'd0);
    model_reset();
    #3;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 6'd0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_occ", 64'(dut.occ), 64'd0);
    chk_credits("reset_credit", 16, 16, 16);

    for (int i = 0; i < 12; i++) begin
      chk_credits("tbl_credit", tbl[i].c0, tbl[i].c1, tbl[i].c2);
      cyc(tbl[i].v, tbl[i].op0, tbl[i].op1, tbl[i].st, 1'b0, 6'd0);
      chk("tbl_ov", obs_ov, tbl[i].ov);
    end

    // Flush with five entries queued and credits at 10/12/14.
    cyc(2'b11, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    cyc(2'b01, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    chk_credits("preflush_credit", 10, 12, 14);
    cyc(2'b11, O_OP, O_LOAD, 1'b1, 1'b0, 6'd0);
    cyc(2'b11, O_JAL, O_OP, 1'b1, 1'b0, 6'd0);
    cyc(2'b01, O_OP, O_OP, 1'b1, 1'b0, 6'd0);
    chk("preflush_occ", 64'(dut.occ), 64'd5);
    cyc(2'b11, O_OP, O_OP, 1'b0, 1'b1, 6'd0);
    chk("flush_cycle_ov", obs_ov, 6'd0);
    chk("postflush_occ", 64'(dut.occ), 64'd0);
    chk_credits("postflush_credit", 16, 16, 16);
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    chk("postflush_ov", obs_ov, 6'd0);

    // Seventeen ALU ops against sixteen credits.
    sent = 0;
    disp = 0;
    for (int n = 0; n < 40; n++) begin
      if (sent < 17 && (QD - mq.size()) >= DW) begin
        v = (17 - sent >= 2) ? 2'b11 : 2'b01;
        sent += (v == 2'b11) ? 2 : 1;
      end else v = 2'b00;
      cyc(v, O_IMM, O_IMM, 1'b0, 1'b0, 6'd0);
      disp += int'(obs_ov[0]) + int'(obs_ov[1]);
    end
    chk("alu_dispatched", 64'(disp), 64'd16);
    chk("alu_held_occ", 64'(dut.occ), 64'd1);
    cyc(2'b00, O_IMM, O_IMM, 1'b0, 1'b0, 6'b000001);
    chk("ret_same_cycle_ov", obs_ov, 6'd0);
    cyc(2'b00, O_IMM, O_IMM, 1'b0, 1'b0, 6'd0);
    chk("ret_next_cycle_ov", obs_ov, 6'b000001);
    cyc(2'b00, O_IMM, O_IMM, 1'b0, 1'b1, 6'd0);

    // BRU exhausted: BEQ at head blocks the younger ADD.
    for (int n = 0; n < 8; n++) cyc(2'b11, O_JAL, O_JAL, 1'b0, 1'b0, 6'd0);
    for (int n = 0; n < 2; n++) cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    chk("bru_exhausted", 64'(dut.credit[2]), 64'd0);
    cyc(2'b11, O_BRANCH, O_OP, 1'b0, 1'b0, 6'd0);
    for (int n = 0; n < 3; n++) begin
      cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
      chk("inorder_block_ov", obs_ov, 6'd0);
    end
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'b010000);
    chk("bru_ret_same_cycle_ov", obs_ov, 6'd0);
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    chk("bru_ret_release_ov", obs_ov, 6'b010001);
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b1, 6'd0);

    // Fill under stall, then drain.
    for (int n = 0; n < 4; n++) cyc(2'b11, O_OP, O_OP, 1'b1, 1'b0, 6'd0);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_occ", 64'(dut.occ), 64'd8);
    cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    chk("drain_ov", obs_ov, 6'b000011);
    chk("drain_in_ready", in_ready, 1'b1);
    for (int n = 0; n < 3; n++) begin
      cyc(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
      chk("drain_more_ov", obs_ov, 6'b000011);
    end
    chk("drained_occ", 64'(dut.occ), 64'd0);

    // Asynchronous reset between edges while entries are pending.
    cyc(2'b11, O_OP, O_LOAD, 1'b0, 1'b0, 6'd0);
    drive(2'b00, O_OP, O_OP, 1'b0, 1'b0, 6'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ov", out_valid, 6'd0);
    chk("async_rst_occ", 64'(dut.occ), 64'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_credit", 64'(dut.credit[0]), 64'd16);
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(2, 0))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      drive(v, ops[$urandom_range(10, 0)], ops[$urandom_range(10, 0)],
            ($urandom_range(9, 0) == 0), ($urandom_range(29, 0) == 0), 6'd0);
      auto_ret = 1'b1;
      run_cycle();
      auto_ret = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
